// File: rtl/wb_arbiter.sv
`timescale 1ns/1ps
// Writeback arbiter: merges load returns and ALU results onto the single register-file
// write port, holding blocked ALU results in order and dropping writes made stale by younger ones.
module wb_arbiter #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int DEPTH = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         AluValid,
  input  logic [D-1:0]                 AluAddr,
  input  logic [W-1:0]                 AluData,
  output logic                         AluReady,
  input  logic                         LdValid,
  input  logic [D-1:0]                 LdAddr,
  input  logic [W-1:0]                 LdData,
  output logic                         WriteEn,
  output logic [D-1:0]                 Waddr,
  output logic [W-1:0]                 DataIn,
  output logic [2**D-1:0]              Pending,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [D-1:0]    buf_addr_q [DEPTH];
  logic [D-1:0]    buf_addr_d [DEPTH];
  logic [W-1:0]    buf_data_q [DEPTH];
  logic [W-1:0]    buf_data_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic            we_q, we_d;
  logic [D-1:0]    waddr_q, waddr_d;
  logic [W-1:0]    data_q, data_d;
  logic [2**D-1:0] pending_q, pending_d;

  logic alu_acc, ld_live, sel_head, sel_alu, push;
  int   n_keep;

  // Ready depends only on registered occupancy, never on this cycle's load.
  assign AluReady = (count_q < DEPTH_C);
  assign alu_acc  = AluValid && AluReady;
  // A load overwritten by the same-cycle (younger) ALU result is dead.
  assign ld_live  = LdValid && !(alu_acc && (LdAddr == AluAddr));
  assign sel_head = !ld_live && (count_q != '0);
  assign sel_alu  = !ld_live && (count_q == '0) && alu_acc;
  assign push     = alu_acc && !sel_alu;

  always_comb begin
    we_d    = ld_live || sel_head || sel_alu;
    waddr_d = waddr_q;
    data_d  = data_q;
    if (ld_live) begin
      waddr_d = LdAddr;
      data_d  = LdData;
    end else if (sel_head) begin
      waddr_d = buf_addr_q[0];
      data_d  = buf_data_q[0];
    end else if (sel_alu) begin
      waddr_d = AluAddr;
      data_d  = AluData;
    end
  end

  // Squash, pop and push fold into one compaction pass: survivors slide toward the head.
  always_comb begin
    n_keep = 0;
    for (int k = 0; k < DEPTH; k++) begin
      buf_addr_d[k] = '0;
      buf_data_d[k] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(count_q)) && !(sel_head && (i == 0)) &&
          !(ld_live && (buf_addr_q[i] == LdAddr))) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (k == n_keep) begin
            buf_addr_d[k] = buf_addr_q[i];
            buf_data_d[k] = buf_data_q[i];
          end
        end
        n_keep = n_keep + 1;
      end
    end
    if (push) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k == n_keep) begin
          buf_addr_d[k] = AluAddr;
          buf_data_d[k] = AluData;
        end
      end
    end
    count_d = CW'(n_keep) + CW'(push);

    pending_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count_d)) pending_d[buf_addr_d[k]] = 1'b1;
    end
    if (we_d) pending_d[waddr_d] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      data_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        buf_addr_q[k] <= '0;
        buf_data_q[k] <= '0;
      end
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      data_q    <= data_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      for (int k = 0; k < DEPTH; k++) begin
        buf_addr_q[k] <= buf_addr_d[k];
        buf_data_q[k] <= buf_data_d[k];
      end
    end
  end

  assign WriteEn = we_q;
  assign Waddr   = waddr_q;
  assign DataIn  = data_q;
  assign Pending = pending_q;
  assign Count   = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
`timescale 1ns/1ps
// Bench for wb_arbiter: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a queue-based model of the writeback rules.
module tb_wb_arbiter;
  localparam int W     = 8;
  localparam int D     = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NR    = 2**D;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          AluValid;
  logic [D-1:0]  AluAddr;
  logic [W-1:0]  AluData;
  logic          AluReady;
  logic          LdValid;
  logic [D-1:0]  LdAddr;
  logic [W-1:0]  LdData;
  logic          WriteEn;
  logic [D-1:0]  Waddr;
  logic [W-1:0]  DataIn;
  logic [NR-1:0] Pending;
  logic [CW-1:0] Count;

  wb_arbiter #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
    .LdValid(LdValid), .LdAddr(LdAddr), .LdData(LdData),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .Pending(Pending), .Count(Count)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  // reference model state: program-ordered buffer of pending ALU results
  typedef struct packed { logic [D-1:0] a; logic [W-1:0] d; } ent_t;
  ent_t           mq[$];
  logic [D+W-1:0] exp_q[$];
  logic           m_init;
  logic           m_we;
  logic [D-1:0]   m_waddr;
  logic [W-1:0]   m_data;
  int             n_cmp;
  int             n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: applies one cycle of inputs, advances the model, checks outputs after the edge
  task automatic cycle(input logic rst,
                       input logic lv, input logic [D-1:0] la, input logic [W-1:0] ld,
                       input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad);
    logic           rdy, acc, ld_ok, wrote;
    ent_t           keep[$];
    ent_t           e;
    logic [D+W-1:0] x;
    logic [NR-1:0]  pend;
    Reset    = rst;
    LdValid  = lv;
    LdAddr   = la;
    LdData   = ld;
    AluValid = av;
    AluAddr  = aa;
    AluData  = ad;
    rdy = (mq.size() < DEPTH);
    if (m_init) check("alu_ready_pre", 32'(AluReady), 32'(rdy));
    acc = av && rdy;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_we    = 1'b0;
      m_waddr = '0;
      m_data  = '0;
      m_init  = 1'b1;
    end else begin
      ld_ok = lv && !(acc && (la == aa));
      m_we  = 1'b1;
      wrote = 1'b0;
      if (ld_ok) begin
        keep = {};
        foreach (mq[i]) if (mq[i].a != la) keep.push_back(mq[i]);
        mq = keep;
        m_waddr = la;
        m_data  = ld;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_waddr = e.a;
        m_data  = e.d;
      end else if (acc) begin
        m_waddr = aa;
        m_data  = ad;
        wrote   = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (acc && !wrote) begin
        e.a = aa;
        e.d = ad;
        mq.push_back(e);
      end
      if (m_we) exp_q.push_back({m_waddr, m_data});
    end

    @(posedge Clk);
    #1;
    pend = '0;
    foreach (mq[i]) pend[mq[i].a] = 1'b1;
    if (m_we) pend[m_waddr] = 1'b1;
    check("write_en", 32'(WriteEn), 32'(m_we));
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (WriteEn === 1'b1) begin
        check("write_addr", 32'(Waddr), 32'(x[D+W-1:W]));
        check("write_data", 32'(DataIn), 32'(x[W-1:0]));
      end
    end
    if (rst) begin
      check("reset_waddr", 32'(Waddr), 32'(0));
      check("reset_data", 32'(DataIn), 32'(0));
    end
    check("count", 32'(Count), 32'(mq.size()));
    check("pending", 32'(Pending), 32'(pend));
    check("alu_ready", 32'(AluReady), 32'(mq.size() < DEPTH));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic rst; logic lv; logic [D-1:0] la; logic [W-1:0] ld;
    logic av; logic [D-1:0] aa; logic [W-1:0] ad;
    logic e_we; logic [D-1:0] e_wa; logic [W-1:0] e_wd; int e_cnt; logic [NR-1:0] e_pend;
  } vec_t;
  vec_t vq[$];

  task automatic vec(input logic rst, input logic lv, input logic [D-1:0] la, input logic [W-1:0] ld,
                     input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                     input logic e_we, input logic [D-1:0] e_wa, input logic [W-1:0] e_wd,
                     input int e_cnt, input logic [NR-1:0] e_pend);
    vec_t v;
    v.rst = rst; v.lv = lv; v.la = la; v.ld = ld; v.av = av; v.aa = aa; v.ad = ad;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_cnt = e_cnt; v.e_pend = e_pend;
    vq.push_back(v);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; m_init = 1'b0;
    m_we = 1'b0; m_waddr = '0; m_data = '0;

    //   rst lv la  ld     av aa  ad      we wa  wd    cnt pend
    vec(0, 0, 0, 8'h00, 1, 3,  8'h5A,  1, 3,  8'h5A, 0, 16'h0008);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  0, 0,  8'h00, 0, 16'h0000);
    vec(0, 1, 2, 8'h11, 1, 5,  8'h22,  1, 2,  8'h11, 1, 16'h0024);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  1, 5,  8'h22, 0, 16'h0020);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  0, 0,  8'h00, 0, 16'h0000);
    vec(0, 1, 4, 8'hAA, 1, 4,  8'hBB,  1, 4,  8'hBB, 0, 16'h0010);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  0, 0,  8'h00, 0, 16'h0000);
    vec(0, 1, 1, 8'h41, 1, 8,  8'h08,  1, 1,  8'h41, 1, 16'h0102);
    vec(0, 1, 2, 8'h42, 1, 9,  8'h09,  1, 2,  8'h42, 2, 16'h0304);
    vec(0, 1, 3, 8'h43, 1, 10, 8'h0A,  1, 3,  8'h43, 2, 16'h0308);
    vec(0, 1, 4, 8'h44, 1, 10, 8'h0A,  1, 4,  8'h44, 2, 16'h0310);
    vec(0, 0, 0, 8'h00, 1, 10, 8'h0A,  1, 8,  8'h08, 1, 16'h0300);
    vec(0, 0, 0, 8'h00, 1, 10, 8'h0A,  1, 9,  8'h09, 1, 16'h0600);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  1, 10, 8'h0A, 0, 16'h0400);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  0, 0,  8'h00, 0, 16'h0000);
    vec(0, 1, 1, 8'h51, 1, 6,  8'h01,  1, 1,  8'h51, 1, 16'h0042);
    vec(0, 1, 2, 8'h52, 1, 7,  8'h02,  1, 2,  8'h52, 2, 16'h00C4);
    vec(0, 1, 6, 8'h33, 0, 0,  8'h00,  1, 6,  8'h33, 1, 16'h00C0);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  1, 7,  8'h02, 0, 16'h0080);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  0, 0,  8'h00, 0, 16'h0000);
    vec(0, 1, 1, 8'h61, 1, 11, 8'h0B,  1, 1,  8'h61, 1, 16'h0802);
    vec(0, 1, 2, 8'h62, 1, 12, 8'h0C,  1, 2,  8'h62, 2, 16'h1804);
    vec(1, 1, 3, 8'h63, 1, 13, 8'h0D,  0, 0,  8'h00, 0, 16'h0000);
    vec(0, 0, 0, 8'h00, 0, 0,  8'h00,  0, 0,  8'h00, 0, 16'h0000);

    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    check("rst_write_en", 32'(WriteEn), 32'(0));
    check("rst_waddr", 32'(Waddr), 32'(0));
    check("rst_data", 32'(DataIn), 32'(0));
    check("rst_count", 32'(Count), 32'(0));
    check("rst_pending", 32'(Pending), 32'(0));
    check("rst_alu_ready", 32'(AluReady), 32'(1));

    foreach (vq[n]) begin
      cycle(vq[n].rst, vq[n].lv, vq[n].la, vq[n].ld, vq[n].av, vq[n].aa, vq[n].ad);
      check($sformatf("vec%0d_we", n), 32'(WriteEn), 32'(vq[n].e_we));
      if (vq[n].e_we) begin
        check($sformatf("vec%0d_waddr", n), 32'(Waddr), 32'(vq[n].e_wa));
        check($sformatf("vec%0d_data", n), 32'(DataIn), 32'(vq[n].e_wd));
      end
      check($sformatf("vec%0d_count", n), 32'(Count), 32'(vq[n].e_cnt));
      check($sformatf("vec%0d_pending", n), 32'(Pending), 32'(vq[n].e_pend));
    end

    // full buffer, load squashes the tail entry: space frees and ALU is taken next cycle
    cycle(1'b0, 1'b1, 4'd1, 8'h71, 1'b1, 4'd6, 8'h16);
    cycle(1'b0, 1'b1, 4'd2, 8'h72, 1'b1, 4'd7, 8'h17);
    check("full_alu_ready", 32'(AluReady), 32'(0));
    cycle(1'b0, 1'b1, 4'd7, 8'h73, 1'b1, 4'd8, 8'h18);
    check("squash_alu_ready", 32'(AluReady), 32'(1));
    check("squash_count", 32'(Count), 32'(1));
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 4'd8, 8'h18);
    check("after_squash_waddr", 32'(Waddr), 32'(6));
    check("after_squash_data", 32'(DataIn), 32'(8'h16));
    idle();
    check("tail_waddr", 32'(Waddr), 32'(8));
    idle();

    // reset held two cycles with full buffer and traffic on both inputs
    cycle(1'b0, 1'b1, 4'd1, 8'h81, 1'b1, 4'd0, 8'h90);
    cycle(1'b0, 1'b1, 4'd2, 8'h82, 1'b1, 4'd15, 8'h91);
    cycle(1'b1, 1'b1, 4'd3, 8'h83, 1'b1, 4'd14, 8'h92);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 4'd13, 8'h93);
    check("hold_rst_write_en", 32'(WriteEn), 32'(0));
    check("hold_rst_count", 32'(Count), 32'(0));
    idle();
    idle();

    for (int c = 0; c < 800; c++) begin
      cycle($urandom_range(0, 79) == 0,
            1'($urandom_range(0, 1)), D'($urandom_range(0, 3)), W'($urandom),
            $urandom_range(0, 9) < 6, D'($urandom_range(0, 3)), W'($urandom));
    end
    for (int c = 0; c < DEPTH + 2; c++) idle();
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
